// File: rtl/multicycle_control.sv
// multicycle_control: control FSM for the multi-cycle MIPS cpu.
// Drives every datapath select and strobe. Memory uses a req/ready handshake.
module multicycle_control #(
  parameter int MEM_TIMEOUT = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       instr_retired,
  output logic       illegal,
  output logic       mem_error,
  output logic [3:0] state
);

  localparam int WW =
    (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WW-1:0] TMO_CNT = WW'(MEM_TIMEOUT);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_R_EXEC    = 4'd2,
    S_R_WB      = 4'd3,
    S_I_EXEC    = 4'd4,
    S_I_WB      = 4'd5,
    S_MEM_ADDR  = 4'd6,
    S_MEM_READ  = 4'd7,
    S_MEM_WB    = 4'd8,
    S_MEM_WRITE = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11
  } state_t;

  state_t        state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [WW-1:0] wait_inc;
  logic          in_mem;
  logic          timed_out;

  // Wait counter bookkeeping; the timeout cycle follows N request cycles.
  always_comb begin
    in_mem = (state_q == S_FETCH) ||
             (state_q == S_MEM_READ) ||
             (state_q == S_MEM_WRITE);
    wait_inc  = '0;
    timed_out = 1'b0;
    if (MEM_TIMEOUT > 0) begin
      wait_inc  = wait_q + WW'(1);
      timed_out = in_mem && (wait_q == TMO_CNT);
    end
  end

  // Next-state and output decode; reset forces every output low.
  always_comb begin
    state_d       = state_q;
    wait_d        = '0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_en         = 1'b0;
    pc_src        = 2'd0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    alu_op        = ALU_ADD;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    instr_retired = 1'b0;
    illegal       = 1'b0;
    mem_error     = 1'b0;
    state         = state_q;

    unique case (state_q)
      S_FETCH: begin
        if (timed_out) begin
          mem_error = 1'b1;
          state_d   = S_FETCH;
        end else begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_write  = 1'b1;
            pc_en     = 1'b1;
            alu_src_b = 2'd1;
            state_d   = S_DECODE;
          end else begin
            wait_d = wait_inc;
          end
        end
      end

      S_DECODE: begin
        alu_src_b = 2'd3;
        unique case (opcode)
          OP_RTYPE:      state_d = S_R_EXEC;
          OP_ADDI:       state_d = S_I_EXEC;
          OP_LW, OP_SW:  state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J:          state_d = S_JUMP;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end

      S_R_EXEC: begin
        alu_src_a = 1'b1;
        state_d   = S_R_WB;
        unique case (funct)
          FN_ADD: alu_op = ALU_ADD;
          FN_SUB: alu_op = ALU_SUB;
          FN_AND: alu_op = ALU_AND;
          FN_OR:  alu_op = ALU_OR;
          FN_SLT: alu_op = ALU_SLT;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end

      S_R_WB: begin
        reg_write     = 1'b1;
        reg_dst       = 1'b1;
        instr_retired = 1'b1;
        state_d       = S_FETCH;
      end

      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        state_d   = S_I_WB;
      end

      S_I_WB: begin
        reg_write     = 1'b1;
        instr_retired = 1'b1;
        state_d       = S_FETCH;
      end

      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        state_d   = (opcode == OP_LW) ? S_MEM_READ
                                      : S_MEM_WRITE;
      end

      S_MEM_READ: begin
        if (timed_out) begin
          mem_error = 1'b1;
          state_d   = S_FETCH;
        end else begin
          mem_req = 1'b1;
          iord    = 1'b1;
          if (mem_ready) state_d = S_MEM_WB;
          else           wait_d  = wait_inc;
        end
      end

      S_MEM_WB: begin
        reg_write     = 1'b1;
        mem_to_reg    = 1'b1;
        instr_retired = 1'b1;
        state_d       = S_FETCH;
      end

      S_MEM_WRITE: begin
        if (timed_out) begin
          mem_error = 1'b1;
          state_d   = S_FETCH;
        end else begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          iord    = 1'b1;
          if (mem_ready) begin
            instr_retired = 1'b1;
            state_d       = S_FETCH;
          end else begin
            wait_d = wait_inc;
          end
        end
      end

      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_src        = 2'd1;
        pc_en         = (opcode == OP_BEQ) ? zero : !zero;
        instr_retired = 1'b1;
        state_d       = S_FETCH;
      end

      S_JUMP: begin
        pc_en         = 1'b1;
        pc_src        = 2'd2;
        instr_retired = 1'b1;
        state_d       = S_FETCH;
      end

      default: state_d = S_FETCH;
    endcase

    if (reset) begin
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      iord          = 1'b0;
      ir_write      = 1'b0;
      pc_en         = 1'b0;
      pc_src        = 2'd0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'd0;
      alu_op        = ALU_ADD;
      reg_write     = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      instr_retired = 1'b0;
      illegal       = 1'b0;
      mem_error     = 1'b0;
      state         = 4'd0;
    end
  end

  // State and wait-counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: randomized check of the control FSM
// against a per-instruction cycle-script model.
module tb_multicycle_control;

  localparam int TMO = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, iord, ir_write, pc_en;
  logic [1:0] pc_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic       reg_write, reg_dst, mem_to_reg;
  logic       instr_retired, illegal, mem_error;
  logic [3:0] state;

  always #5 clock = ~clock;

  multicycle_control #(.MEM_TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset),
    .opcode(opcode), .funct(funct),
    .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we),
    .iord(iord), .ir_write(ir_write),
    .pc_en(pc_en), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .instr_retired(instr_retired),
    .illegal(illegal), .mem_error(mem_error),
    .state(state)
  );

  typedef struct packed {
    logic       req, we, iord, irw, pce;
    logic [1:0] pcs;
    logic       a;
    logic [1:0] b;
    logic [2:0] op;
    logic       rw, rd, m2r, ret, ill, err;
  } out_t;

  typedef struct {
    logic rdy;
    logic z;
    logic fet;
    out_t o;
  } step_t;

  out_t obs;
  assign obs = {mem_req, mem_we, iord, ir_write, pc_en,
                pc_src, alu_src_a, alu_src_b, alu_op,
                reg_write, reg_dst, mem_to_reg,
                instr_retired, illegal, mem_error};

  step_t q[$];
  int    n_chk = 0;
  int    n_err = 0;
  int    extra;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit legal_op(input logic [5:0] o);
    return o == 6'h00 || o == 6'h08 || o == 6'h23 ||
           o == 6'h2B || o == 6'h04 || o == 6'h05 ||
           o == 6'h02;
  endfunction

  function automatic int fn_op(input logic [5:0] f);
    case (f)
      6'h20: return 0;
      6'h22: return 1;
      6'h24: return 2;
      6'h25: return 3;
      6'h2A: return 4;
      default: return -1;
    endcase
  endfunction

  task automatic push(input logic r, input logic z,
                      input logic f, input out_t o);
    step_t s;
    s.rdy = r; s.z = z; s.fet = f; s.o = o;
    q.push_back(s);
  endtask

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  // One memory access: kind 0 fetch, 1 read, 2 write.
  task automatic push_access(input int kind, input int waits,
                             output bit ok);
    out_t o;
    o = '0;
    o.req = 1'b1;
    o.iord = (kind != 0);
    o.we = (kind == 2);
    if (waits >= TMO) begin
      for (int i = 0; i < TMO; i++) push(1'b0, rb(), kind == 0, o);
      o = '0;
      o.err = 1'b1;
      push(1'b0, rb(), kind == 0, o);
      extra += TMO + 1;
      ok = 1'b0;
    end else begin
      for (int i = 0; i < waits; i++) push(1'b0, rb(), kind == 0, o);
      extra += waits;
      if (kind == 0) begin
        o.irw = 1'b1; o.pce = 1'b1; o.b = 2'd1;
      end
      if (kind == 2) o.ret = 1'b1;
      push(1'b1, rb(), kind == 0, o);
      ok = 1'b1;
    end
  endtask

  task automatic build(input logic [5:0] opc, input logic [5:0] fn,
                       input logic zb, input int fw, input int dw,
                       output int base, output bit retires);
    out_t o;
    bit   ok;
    int   aop;
    q.delete();
    extra = 0;
    base = 0;
    retires = 1'b0;
    push_access(0, fw, ok);
    while (!ok) push_access(0, 0, ok);
    o = '0;
    o.b = 2'd3;
    if (!legal_op(opc)) begin
      o.ill = 1'b1;
      push(rb(), rb(), 1'b0, o);
      return;
    end
    push(rb(), rb(), 1'b0, o);
    o = '0;
    case (opc)
      6'h00: begin
        aop = fn_op(fn);
        o.a = 1'b1;
        if (aop < 0) begin
          o.ill = 1'b1;
          push(rb(), rb(), 1'b0, o);
          return;
        end
        o.op = 3'(aop);
        push(rb(), rb(), 1'b0, o);
        o = '0; o.rw = 1'b1; o.rd = 1'b1; o.ret = 1'b1;
        push(rb(), rb(), 1'b0, o);
        base = 4;
      end
      6'h08: begin
        o.a = 1'b1; o.b = 2'd2;
        push(rb(), rb(), 1'b0, o);
        o = '0; o.rw = 1'b1; o.ret = 1'b1;
        push(rb(), rb(), 1'b0, o);
        base = 4;
      end
      6'h23, 6'h2B: begin
        o.a = 1'b1; o.b = 2'd2;
        push(rb(), rb(), 1'b0, o);
        push_access((opc == 6'h23) ? 1 : 2, dw, ok);
        if (!ok) return;
        if (opc == 6'h23) begin
          o = '0; o.rw = 1'b1; o.m2r = 1'b1; o.ret = 1'b1;
          push(rb(), rb(), 1'b0, o);
          base = 5;
        end else begin
          base = 4;
        end
      end
      6'h04, 6'h05: begin
        o.a = 1'b1; o.op = 3'd1; o.pcs = 2'd1; o.ret = 1'b1;
        o.pce = (opc == 6'h04) ? zb : !zb;
        push(rb(), zb, 1'b0, o);
        base = 3;
      end
      default: begin
        o.pce = 1'b1; o.pcs = 2'd2; o.ret = 1'b1;
        push(rb(), rb(), 1'b0, o);
        base = 3;
      end
    endcase
    retires = 1'b1;
  endtask

  task automatic run(input string name, input logic [5:0] opc,
                     input logic [5:0] fn, input logic zb,
                     input int fw, input int dw, input int rst_at);
    int base;
    bit rt;
    int ret_at;
    int idx;
    build(opc, fn, zb, fw, dw, base, rt);
    ret_at = -1;
    idx = 0;
    foreach (q[i]) begin
      if (idx == rst_at) begin
        @(negedge clock);
        reset = 1'b1;
        mem_ready = 1'b1;
        #1;
        check({name, " rst_out"}, 32'(obs), 32'd0);
        check({name, " rst_state"}, 32'(state), 32'd0);
        check({name, " noret"}, ret_at, -1);
        @(posedge clock);
        #1;
        reset = 1'b0;
        mem_ready = 1'b0;
        return;
      end
      @(negedge clock);
      mem_ready = q[i].rdy;
      zero = q[i].z;
      if (q[i].fet) begin
        opcode = 6'($urandom);
        funct = 6'($urandom);
      end else begin
        opcode = opc;
        funct = fn;
      end
      #1;
      check({name, " out"}, 32'(obs), 32'(q[i].o));
      if (instr_retired && ret_at < 0) ret_at = idx + 1;
      idx++;
    end
    if (rt) check({name, " cycles"}, ret_at, base + extra);
    else    check({name, " noret"}, ret_at, -1);
  endtask

  task automatic do_reset(input int n);
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      mem_ready = rb();
      zero = rb();
      opcode = 6'($urandom);
      funct = 6'($urandom);
      #1;
      check("reset out", 32'(obs), 32'd0);
      check("reset state", 32'(state), 32'd0);
      @(negedge clock);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    mem_ready = 1'b0;
  endtask

  initial begin
    logic [5:0] ro, rf;
    logic [5:0] ops [7];
    logic [5:0] fns [5];
    int fw, dw;
    ops = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

    do_reset(3);
    run("addi_t0", 6'h08, 6'h06, 1'b0, 0, 0, -1);
    run("addi_t1", 6'h08, 6'h0B, 1'b0, 0, 0, -1);
    run("add_t2", 6'h00, 6'h20, 1'b0, 0, 0, -1);
    run("lw_wait2", 6'h23, 6'h00, 1'b0, 0, 2, -1);
    run("beq_z1", 6'h04, 6'h00, 1'b1, 0, 0, -1);
    run("beq_z0", 6'h04, 6'h00, 1'b0, 0, 0, -1);
    run("bne_z1", 6'h05, 6'h00, 1'b1, 0, 0, -1);
    run("bne_z0", 6'h05, 6'h00, 1'b0, 0, 0, -1);
    run("j", 6'h02, 6'h00, 1'b0, 1, 0, -1);
    run("sub", 6'h00, 6'h22, 1'b0, 0, 0, -1);
    run("and", 6'h00, 6'h24, 1'b0, 0, 0, -1);
    run("or", 6'h00, 6'h25, 1'b0, 0, 0, -1);
    run("slt", 6'h00, 6'h2A, 1'b0, 0, 0, -1);
    run("sw", 6'h2B, 6'h00, 1'b0, 0, 1, -1);
    run("ill_op", 6'h3F, 6'h00, 1'b0, 0, 0, -1);
    run("ill_fn", 6'h00, 6'h00, 1'b0, 0, 0, -1);
    run("sw_rst", 6'h2B, 6'h00, 1'b0, 0, 3, 4);
    run("after_rst", 6'h08, 6'h00, 1'b0, 0, 0, -1);
    run("fetch_tmo", 6'h08, 6'h00, 1'b0, 4, 0, -1);
    run("ready_nth", 6'h23, 6'h00, 1'b0, 3, 3, -1);
    run("read_tmo", 6'h23, 6'h00, 1'b0, 0, 5, -1);
    run("write_tmo", 6'h2B, 6'h00, 1'b0, 0, 4, -1);

    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        do ro = 6'($urandom); while (legal_op(ro));
      end else begin
        ro = ops[$urandom_range(0, 6)];
      end
      if ($urandom_range(0, 4) == 0) rf = 6'($urandom);
      else rf = fns[$urandom_range(0, 4)];
      fw = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 5)
                                       : $urandom_range(0, 3);
      dw = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 5)
                                       : $urandom_range(0, 3);
      run("rand", ro, rf, rb(), fw, dw, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Control FSM for the multi-cycle build of the MIPS `cpu`. It sequences one shared ALU and one unified instruction/data memory through fetch, decode, execute, memory and writeback. It drives every datapath select and enable, including the PC, IR, regfile and memory strobes. It also handles a variable-latency memory via a req/ready handshake.

## Interface
- `MEM_TIMEOUT`, default 0: maximum cycles a memory wait may last before abort; 0 disables the timeout.
- `clock` in 1: single system clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `opcode` in 6: IR[31:26]; valid from DECODE onward.
- `funct` in 6: IR[5:0].
- `zero` in 1: ALU zero flag for the current-cycle ALU result.
- `mem_ready` in 1: memory completes the access this cycle.
- `mem_req` out 1: memory access request.
- `mem_we` out 1: write strobe, qualified by `mem_req`.
- `iord` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `ir_write` out 1: load IR from memory read data.
- `pc_en` out 1: load PC this cycle.
- `pc_src` out 2: 0 = ALU result, 1 = ALUOut, 2 = {PC[31:28], IR[25:0], 2'b00}.
- `alu_src_a` out 1: 0 = PC, 1 = A.
- `alu_src_b` out 2: 0 = B, 1 = constant 4, 2 = sign-extended imm, 3 = sign-extended imm<<2.
- `alu_op` out 3: 0 = add, 1 = sub, 2 = and, 3 = or, 4 = slt.
- `reg_write` out 1: regfile write enable.
- `reg_dst` out 1: 0 = rt, 1 = rd.
- `mem_to_reg` out 1: 0 = ALUOut, 1 = MDR.
- `instr_retired` out 1: one-cycle pulse in an instruction's final cycle.
- `illegal` out 1: one-cycle pulse on an unsupported opcode or funct.
- `mem_error` out 1: one-cycle pulse on a memory timeout.
- `state` out 4: current state, for debug.

## Operation
- State transitions and outputs:
  - FETCH: `mem_req`=1, `iord`=0; hold until `mem_ready`.
  - On ready in FETCH: `ir_write`, ALU computes PC+4 (`alu_src_a`=0, `alu_src_b`=1, add), `pc_en`=1, `pc_src`=0; go to DECODE.
  - DECODE: ALU computes PC+imm<<2 into ALUOut, then dispatches on `opcode`:
    - 0x00 → R_EXEC
    - 0x08 → I_EXEC
    - 0x23 or 0x2B → MEM_ADDR
    - 0x04 or 0x05 → BRANCH
    - 0x02 → JUMP
    - other → `illegal` pulse, then FETCH.
  - R_EXEC: A op B, with `alu_op` from `funct`: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt. Any other funct → `illegal`, then FETCH, with no write.
  - R_WB: `reg_write`, `reg_dst`=1, `mem_to_reg`=0, retire.
  - I_EXEC: A + imm. I_WB: `reg_write`, `reg_dst`=0, retire.
  - MEM_ADDR: A + imm into ALUOut. lw → MEM_READ; sw → MEM_WRITE.
  - MEM_READ: `mem_req`, `iord`=1; hold until `mem_ready`, then MEM_WB.
  - MEM_WB: `reg_write`, `reg_dst`=0, `mem_to_reg`=1, retire.
  - MEM_WRITE: `mem_req`, `mem_we`, `iord`=1; hold until `mem_ready`, then retire.
  - BRANCH: A − B (`alu_op`=1, `alu_src_b`=0), `pc_src`=1.
    - `pc_en` = `zero` for beq and !`zero` for bne.
    - Retire either way.
  - JUMP: `pc_en`, `pc_src`=2, retire.
  - Every retiring state and every abort returns to FETCH.
- All strobes default to 0 in states that do not drive them. Select outputs default to 0.
- Outputs are combinational from the registered state plus `mem_ready`, `zero`, `opcode` and `funct`. `pc_en` depends on `zero` only in BRANCH.

## Timing
- Reset: `state`=FETCH. While `reset`=1, all outputs are forced to 0, including `mem_req`. The first fetch request appears in the cycle after `reset` falls.
- Reset during any wait abandons the access. `mem_req` drops in the same cycle; there is no retire and no writeback.
- Cycle counts with `mem_ready` asserted in the first request cycle:
  - lw: 5 cycles.
  - sw, R-type, addi: 4 cycles.
  - beq, bne, j: 3 cycles.
  - Each wait cycle adds 1.
- Handshake: `mem_req`, `iord` and `mem_we` stay stable until and including the `mem_ready` cycle. `mem_ready` is ignored outside FETCH, MEM_READ and MEM_WRITE.
- Timeout (`MEM_TIMEOUT`=N>0): a wait counter clears on entry to each memory state.
  - If N cycles pass without `mem_ready`, the FSM pulses `mem_error` and returns to FETCH. `mem_req` falls.
  - A fetch timeout does not advance the PC, so the same address is refetched.
  - `mem_ready` in the Nth cycle wins over the timeout.
- The bne-taken and beq-taken decision uses `zero` sampled in the BRANCH cycle only.

## Test plan
- Reset, then the instruction stream `addi t0,zero,6`, `addi t1,zero,11`, `add t2,t0,t1`, with zero-wait memory → `instr_retired` pulses at cycles 4, 8 and 12 after reset release. The writes go to t0=6, t1=11, t2=17. `reg_dst`=1 on the third write.
- lw with `mem_ready` delayed 2 cycles in MEM_READ → `mem_req`/`iord`=1 held for 3 cycles, `reg_write` with `mem_to_reg`=1 at cycle 7, 7 cycles total.
- beq with `zero`=1 → `pc_en`=1, `pc_src`=1. Repeat with `zero`=0 → `pc_en`=0. For bne the two results invert. All cases take 3 cycles.
- opcode 0x3F, then R-type with funct 0x00 → `illegal` pulses in DECODE and in R_EXEC respectively. `reg_write` never asserts; the FSM is in FETCH next cycle.
- `reset` asserted in the second wait cycle of MEM_WRITE → `mem_req` and `mem_we` are 0 in that same cycle, `state`=FETCH afterward, and there is no `instr_retired`.
- `MEM_TIMEOUT`=4 with `mem_ready` held low in FETCH → `mem_error` pulses after 4 request cycles, no `pc_en`, and a new fetch follows.
